// File: rtl/simmem_release_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : simmem_release_scheduler
// Purpose  : Picks one releasable bank slot at a time from two classes
//            (write responses and read data), presents it as a valid/ready
//            grant, and emits a one-cycle onehot release pulse on handshake.
//            Round-robin inside each class; class arbitration either
//            alternates (default) or always favours write responses.
// Ports    : clk_i, rst_ni                      clock / async active-low reset
//            write_resp_release_en_i [WR]       eligible write-resp slots
//            read_data_release_en_i  [RD]       eligible read-data slots
//            release_valid_o / release_ready_i  grant handshake
//            release_is_write_resp_o            granted class (1 = write-resp)
//            release_addr_o [MaxBankAddrWidth]  granted slot index
//            write_resp_address_released_onehot_o / read_data_address_released_onehot_o
//                                               release pulses (handshake cycle)
// Macro    : SIMMEM_RELEASE_FIXED_PRIO_EN -- write-resp wins every contest
//            between classes instead of alternating.
// Revision : 1.0  initial release
// ============================================================================
module simmem_release_scheduler #(
  parameter int WriteRespBankTotalCapacity = 64,
  parameter int ReadDataBankTotalCapacity  = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [WriteRespBankTotalCapacity-1:0] write_resp_release_en_i,
  input  logic [ReadDataBankTotalCapacity-1:0]  read_data_release_en_i,
  output logic                                  release_valid_o,
  input  logic                                  release_ready_i,
  output logic                                  release_is_write_resp_o,
  output logic [$clog2((WriteRespBankTotalCapacity > ReadDataBankTotalCapacity) ?
                       WriteRespBankTotalCapacity : ReadDataBankTotalCapacity)-1:0]
                                                release_addr_o,
  output logic [WriteRespBankTotalCapacity-1:0] write_resp_address_released_onehot_o,
  output logic [ReadDataBankTotalCapacity-1:0]  read_data_address_released_onehot_o
);

  localparam int MaxBankAddrWidth = $clog2((WriteRespBankTotalCapacity > ReadDataBankTotalCapacity) ?
                                           WriteRespBankTotalCapacity : ReadDataBankTotalCapacity);
  localparam int c_WR_AW = $clog2(WriteRespBankTotalCapacity);
  localparam int c_RD_AW = $clog2(ReadDataBankTotalCapacity);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_HOLD = 1'b1;

  logic [0:0]                  r_state;
  logic                        r_is_wr;
  logic [MaxBankAddrWidth-1:0] r_addr;
  logic [c_WR_AW-1:0]          r_wr_ptr;
  logic [c_RD_AW-1:0]          r_rd_ptr;

  logic                                  w_hs;
  logic                                  w_sel_en;
  logic [WriteRespBankTotalCapacity-1:0] w_wr_oh;
  logic [ReadDataBankTotalCapacity-1:0]  w_rd_oh;
  logic [WriteRespBankTotalCapacity-1:0] w_wr_elig;
  logic [ReadDataBankTotalCapacity-1:0]  w_rd_elig;
  logic [c_WR_AW-1:0]                    w_wr_ptr_eff;
  logic [c_RD_AW-1:0]                    w_rd_ptr_eff;
  logic [c_WR_AW-1:0]                    w_wr_scan;
  logic [c_RD_AW-1:0]                    w_rd_scan;
  logic [c_WR_AW-1:0]                    w_wr_idx;
  logic [c_RD_AW-1:0]                    w_rd_idx;
  logic                                  w_wr_found;
  logic                                  w_rd_found;
  logic                                  w_pick_wr;

`ifndef SIMMEM_RELEASE_FIXED_PRIO_EN
  // r_prio = 1 favours write-resp; r_both remembers whether the held grant
  // was chosen while both classes were competing.
  logic r_prio;
  logic r_both;
  logic w_prio_eff;
`endif

  assign w_hs     = (r_state == c_ST_HOLD) && release_ready_i;
  assign w_sel_en = (r_state == c_ST_IDLE) || w_hs;

  assign w_wr_oh = (w_hs && r_is_wr)  ? (WriteRespBankTotalCapacity'(1) << r_addr[c_WR_AW-1:0]) : '0;
  assign w_rd_oh = (w_hs && !r_is_wr) ? (ReadDataBankTotalCapacity'(1)  << r_addr[c_RD_AW-1:0]) : '0;

  assign write_resp_address_released_onehot_o = w_wr_oh;
  assign read_data_address_released_onehot_o  = w_rd_oh;

  // The slot being released this cycle still shows as eligible upstream,
  // so it is masked out of the back-to-back reselection.
  assign w_wr_elig = write_resp_release_en_i & ~w_wr_oh;
  assign w_rd_elig = read_data_release_en_i  & ~w_rd_oh;

  // Reselection in a handshake cycle must already see the advanced pointer
  // and toggled priority, hence these "effective" next-state values.
  assign w_wr_ptr_eff = (w_hs && r_is_wr)  ? (r_addr[c_WR_AW-1:0] + c_WR_AW'(1)) : r_wr_ptr;
  assign w_rd_ptr_eff = (w_hs && !r_is_wr) ? (r_addr[c_RD_AW-1:0] + c_RD_AW'(1)) : r_rd_ptr;

  // Round-robin scan: descending offset so the smallest offset from the
  // pointer is the last (winning) assignment. Wrap is free (power of two).
  always_comb begin
    w_wr_found = 1'b0;
    w_wr_idx   = '0;
    w_wr_scan  = '0;
    for (int i = WriteRespBankTotalCapacity - 1; i >= 0; i--) begin
      w_wr_scan = w_wr_ptr_eff + c_WR_AW'(i);
      if (w_wr_elig[w_wr_scan]) begin
        w_wr_found = 1'b1;
        w_wr_idx   = w_wr_scan;
      end
    end
  end

  always_comb begin
    w_rd_found = 1'b0;
    w_rd_idx   = '0;
    w_rd_scan  = '0;
    for (int i = ReadDataBankTotalCapacity - 1; i >= 0; i--) begin
      w_rd_scan = w_rd_ptr_eff + c_RD_AW'(i);
      if (w_rd_elig[w_rd_scan]) begin
        w_rd_found = 1'b1;
        w_rd_idx   = w_rd_scan;
      end
    end
  end

`ifdef SIMMEM_RELEASE_FIXED_PRIO_EN
  assign w_pick_wr = w_wr_found;
`else
  assign w_prio_eff = (w_hs && r_both) ? ~r_prio : r_prio;
  assign w_pick_wr  = w_wr_found && (!w_rd_found || w_prio_eff);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= c_ST_IDLE;
      r_is_wr  <= 1'b0;
      r_addr   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
`ifndef SIMMEM_RELEASE_FIXED_PRIO_EN
      r_prio   <= 1'b1;
      r_both   <= 1'b0;
`endif
    end else begin
      r_wr_ptr <= w_wr_ptr_eff;
      r_rd_ptr <= w_rd_ptr_eff;
`ifndef SIMMEM_RELEASE_FIXED_PRIO_EN
      r_prio   <= w_prio_eff;
`endif
      if (w_sel_en) begin
        if (w_wr_found || w_rd_found) begin
          r_state <= c_ST_HOLD;
          r_is_wr <= w_pick_wr;
          r_addr  <= w_pick_wr ? MaxBankAddrWidth'(w_wr_idx) : MaxBankAddrWidth'(w_rd_idx);
`ifndef SIMMEM_RELEASE_FIXED_PRIO_EN
          r_both  <= w_wr_found && w_rd_found;
`endif
        end else begin
          r_state <= c_ST_IDLE;
        end
      end
    end
  end

  assign release_valid_o         = (r_state == c_ST_HOLD);
  assign release_is_write_resp_o = r_is_wr;
  assign release_addr_o          = r_addr;

endmodule
`default_nettype wire

// File: doc/simmem_release_scheduler.md
SIMMEM_RELEASE_SCHEDULER -- requirements
Module: simmem_release_scheduler

Interface
REQ-001 SHALL have parameter WriteRespBankTotalCapacity, 64, number of write-response bank slots (power of two, >=2).
REQ-002 SHALL have parameter ReadDataBankTotalCapacity, 64, number of read-data bank slots (power of two, >=2).
REQ-003 SHALL derive localparam MaxBankAddrWidth = clog2(max(WriteRespBankTotalCapacity, ReadDataBankTotalCapacity)).
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port write_resp_release_en_i  input  WriteRespBankTotalCapacity  multihot, slots eligible for release.
REQ-007 SHALL have port read_data_release_en_i  input  ReadDataBankTotalCapacity  multihot, slots eligible for release.
REQ-008 SHALL have port release_valid_o  output  1  a release grant is presented.
REQ-009 SHALL have port release_ready_i  input  1  downstream accepts the grant.
REQ-010 SHALL have port release_is_write_resp_o  output  1  granted class: 1 write-resp, 0 read-data.
REQ-011 SHALL have port release_addr_o  output  MaxBankAddrWidth  binary slot index of the grant.
REQ-012 SHALL have port write_resp_address_released_onehot_o  output  WriteRespBankTotalCapacity  one-cycle onehot release pulse.
REQ-013 SHALL have port read_data_address_released_onehot_o  output  ReadDataBankTotalCapacity  one-cycle onehot release pulse.

Function
REQ-014 SHALL implement two states: IDLE (release_valid_o=0) and HOLD (release_valid_o=1).
REQ-015 IDLE: if any unmasked eligible bit exists, SHALL register the selection and enter HOLD next cycle; latency from eligibility to release_valid_o = 1 cycle.
REQ-016 HOLD: release_is_write_resp_o and release_addr_o SHALL stay stable until release_valid_o && release_ready_i.
REQ-017 On handshake, the matching onehot output SHALL assert exactly the granted bit in that same cycle (combinational from held registers and release_ready_i); otherwise both onehot outputs SHALL be zero.
REQ-018 On handshake, if another unmasked eligible bit exists, SHALL load it and remain in HOLD (back-to-back, one grant per cycle); else SHALL return to IDLE.
REQ-019 The currently held slot SHALL be masked from eligibility in the handshake cycle (its release_en bit clears one cycle later upstream).
REQ-020 Within each class, selection SHALL be round-robin: first eligible index at or above that class pointer, wrapping modulo capacity.
REQ-021 On each grant handshake, the granted class pointer SHALL become (granted index + 1) modulo capacity; wrap from capacity-1 to 0.
REQ-022 Class choice: if only one class eligible, that class; if both, the class flagged by a priority bit, which SHALL toggle after each handshake where both classes were eligible at selection.
REQ-023 Eligibility changes while in HOLD SHALL NOT alter the held grant.
REQ-024 release_addr_o upper bits SHALL be zero when the granted class capacity is smaller than the maximum.

Reset
REQ-025 On rst_ni low, asynchronously: state IDLE, release_valid_o=0, release_is_write_resp_o=0, release_addr_o=0, both pointers 0, priority bit = write-resp; onehot outputs SHALL be zero.
REQ-026 Reset asserted during HOLD SHALL drop the grant without a release pulse; first grant after deassertion follows REQ-015.

Configuration
REQ-027 Macro SIMMEM_RELEASE_FIXED_PRIO_EN defined: write-resp class SHALL always win when both classes eligible; priority bit removed.
REQ-028 Macro undefined: class arbitration SHALL follow REQ-022 alternation; in-class round-robin unaffected either way.

Verification
REQ-029 Reset, write_resp_release_en_i=0x1, ready=1 -> valid_o high next cycle, is_write_resp=1, addr=0, write onehot=0x1 same cycle; IDLE afterwards.
REQ-030 write en=0x0F held, ready=1 continuously -> grants addr 0,1,2,3 on consecutive cycles; no duplicate grant of any slot.
REQ-031 Both classes: write en bit 5, read en bit 9, ready=1 -> write 5 then read 9 (macro off); pattern repeated with macro on and write always pending -> write wins every contest.
REQ-032 ready=0 for 4 cycles with changing release_en -> addr/class stable, no onehot pulses; pulse on first ready cycle.
REQ-033 Pointer at 62, write en bits 1 and 63 (capacity 64) -> grants 63 then 1 (wrap).
REQ-034 rst_ni pulsed low during HOLD -> valid_o drops immediately, no onehot pulse, pointers return to 0.
